// File: rtl/oet_sorter_if.sv
// Stream bundle for oet_sorter: load side, drain side and the busy flag.
// slave is the sorter's view; master is the view of whoever feeds and drains it.
interface oet_sorter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  busy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/oet_sorter.sv
// Serial-in/serial-out odd-even transposition sorter, drains largest first.
// Define SORT_MEDIAN_ONLY_EN to drain only the median entry as a single beat.
module oet_sorter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM        = 9
) (
  input  logic        clk,
  input  logic        rst,
  oet_sorter_if.slave bus
);
  localparam int CNT_W = $clog2(NUM + 1);
  localparam int IDX_W = $clog2(NUM);
`ifdef SORT_MEDIAN_ONLY_EN
  localparam int FIRST_IDX = (NUM - 1) / 2;
  localparam int LAST_IDX  = (NUM - 1) / 2;
`else
  localparam int FIRST_IDX = 0;
  localparam int LAST_IDX  = NUM - 1;
`endif
  localparam logic [CNT_W-1:0] C_END   = CNT_W'(NUM - 1);
  localparam logic [CNT_W-1:0] C_FIRST = CNT_W'(FIRST_IDX);
  localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(LAST_IDX);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SORT, S_DRAIN} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_armed;
  logic [DATA_WIDTH-1:0] r_mem    [NUM];
  logic [DATA_WIDTH-1:0] w_sorted [NUM];
  logic [NUM-2:0]        w_swap;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_in_ready;
  logic                  w_in_fire;
  logic                  w_out_fire;

  assign w_idx      = r_cnt[IDX_W-1:0];
  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_out_fire = bus.out_ready && (r_state == S_DRAIN);

  // r_cnt doubles as the pass number in SORT, so its LSB picks even/odd pairing.
  genvar gi;
  generate
    for (gi = 0; gi < NUM - 1; gi++) begin : g_pair
      localparam bit ODD = (gi % 2) == 1;
      assign w_swap[gi] = (r_cnt[0] == ODD) && (r_mem[gi] < r_mem[gi+1]);
    end
    for (gi = 0; gi < NUM; gi++) begin : g_elem
      if (gi == 0) begin : g_head
        assign w_sorted[gi] = w_swap[gi] ? r_mem[gi+1] : r_mem[gi];
      end else if (gi == NUM - 1) begin : g_tail
        assign w_sorted[gi] = w_swap[gi-1] ? r_mem[gi-1] : r_mem[gi];
      end else begin : g_mid
        assign w_sorted[gi] = w_swap[gi-1] ? r_mem[gi-1] :
                              w_swap[gi]   ? r_mem[gi+1] : r_mem[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_in_fire) w_state_next = S_LOAD;
      S_LOAD:  if (w_in_fire && r_cnt == C_END) w_state_next = S_SORT;
      S_SORT:  if (r_cnt == C_END) w_state_next = S_DRAIN;
      S_DRAIN: if (w_out_fire && r_cnt == C_LAST) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready    = r_armed && (r_state == S_IDLE || r_state == S_LOAD);
    bus.in_ready  = w_in_ready;
    bus.out_valid = (r_state == S_DRAIN);
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    bus.busy      = (r_state != S_IDLE);
    if (r_state == S_DRAIN) begin
      bus.out_data = r_mem[w_idx];
      bus.out_last = (r_cnt == C_LAST);
    end
  end

  // r_armed keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_armed <= 1'b0;
      for (int i = 0; i < NUM; i++) r_mem[i] <= '0;
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        S_IDLE, S_LOAD: begin
          if (w_in_fire) begin
            r_mem[w_idx] <= bus.in_data;
            r_cnt        <= (r_cnt == C_END) ? '0 : r_cnt + 1'b1;
          end
        end
        S_SORT: begin
          r_mem <= w_sorted;
          r_cnt <= (r_cnt == C_END) ? C_FIRST : r_cnt + 1'b1;
        end
        S_DRAIN: begin
          if (w_out_fire) r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
        end
        default: r_cnt <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_oet_sorter.sv
// Directed-vector bench for oet_sorter (NUM=9 and NUM=2 instances).
// Expectations follow SORT_MEDIAN_ONLY_EN when the bench is built with it.
module tb_oet_sorter;
  typedef logic [7:0] win_t [9];

`ifdef SORT_MEDIAN_ONLY_EN
  localparam bit MED = 1'b1;
`else
  localparam bit MED = 1'b0;
`endif
  localparam int N9   = MED ? 1 : 9;
  localparam int N2   = MED ? 1 : 2;
  localparam int MIDX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  oet_sorter_if #(.DATA_WIDTH(8)) if9 ();
  oet_sorter_if #(.DATA_WIDTH(8)) if2 ();

  oet_sorter #(.DATA_WIDTH(8), .NUM(9)) dut9 (.clk(clk), .rst(rst), .bus(if9));
  oet_sorter #(.DATA_WIDTH(8), .NUM(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the 9th accepting edge.
  task automatic load_win(input win_t v, input bit gaps);
    int w;
    for (int k = 0; k < 9; k++) begin
      if (gaps && (k % 3 == 1)) begin
        if9.in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
      end
      if9.in_valid = 1'b1;
      if9.in_data  = v[k];
      w = 0;
      while (!if9.in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w >= 50) check_eq("load_ready", {31'd0, if9.in_ready}, 32'd1);
      @(posedge clk); @(negedge clk);
    end
    if9.in_valid = 1'b0;
  endtask

  task automatic wait_sort(input bit chk_in);
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); @(negedge clk);
      if (c == 1) check_eq("sort_busy", {31'd0, if9.busy}, 32'd1);
      if (chk_in && (c == 1 || c == 5)) check_eq("sort_in_ready", {31'd0, if9.in_ready}, 32'd0);
      if (c == 8) check_eq("lat_early", {31'd0, if9.out_valid}, 32'd0);
      if (c == 9) check_eq("lat_first", {31'd0, if9.out_valid}, 32'd1);
    end
  endtask

  task automatic drain(input win_t exp, input bit stall, input bit chk_in);
    logic [3:0] pat;
    logic       rdy;
    logic [7:0] e;
    int beat;
    int cyc;
    pat  = 4'b1001;
    beat = 0;
    cyc  = 0;
    while (beat < N9 && cyc < 200) begin
      rdy = stall ? pat[3 - (cyc % 4)] : 1'b1;
      if9.out_ready = rdy;
      if (if9.out_valid) begin
        e = MED ? exp[MIDX] : exp[beat];
        check_eq("out_data", {24'd0, if9.out_data}, {24'd0, e});
        check_eq("out_last", {31'd0, if9.out_last}, {31'd0, beat == N9 - 1});
        if (chk_in) check_eq("drain_in_ready", {31'd0, if9.in_ready}, 32'd0);
        if (rdy) beat++;
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    if (beat < N9) check_eq("drain_timeout", beat, N9);
    if9.out_ready = 1'b0;
    check_eq("post_out_valid", {31'd0, if9.out_valid}, 32'd0);
    check_eq("post_busy", {31'd0, if9.busy}, 32'd0);
    check_eq("post_in_ready", {31'd0, if9.in_ready}, 32'd1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    win_t v_up, e_dn, v_dup, e_dup, v_dn, v_mix, v_med, e_med, v_aa;
    logic [7:0] e2 [2];
    int beat;
    int cyc;
    v_up  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    e_dn  = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    v_dup = '{8'd7, 8'd7, 8'd3, 8'd255, 8'd0, 8'd7, 8'd3, 8'd0, 8'd255};
    e_dup = '{8'd255, 8'd255, 8'd7, 8'd7, 8'd7, 8'd3, 8'd3, 8'd0, 8'd0};
    v_dn  = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    v_mix = '{8'd5, 8'd1, 8'd8, 8'd2, 8'd9, 8'd3, 8'd7, 8'd4, 8'd6};
    v_med = '{8'd5, 8'd200, 8'd3, 8'd17, 8'd90, 8'd1, 8'd64, 8'd8, 8'd42};
    e_med = '{8'd200, 8'd90, 8'd64, 8'd42, 8'd17, 8'd8, 8'd5, 8'd3, 8'd1};
    v_aa  = '{8'd4, 8'd250, 8'd0, 8'd17, 8'd171, 8'd169, 8'd4, 8'd100, 8'd2};
    e2    = '{8'd9, 8'd3};

    if9.in_valid = 1'b0; if9.in_data = '0; if9.out_ready = 1'b0;
    if2.in_valid = 1'b0; if2.in_data = '0; if2.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", {31'd0, if9.in_ready}, 32'd0);
    check_eq("rst_out_valid", {31'd0, if9.out_valid}, 32'd0);
    check_eq("rst_out_data", {24'd0, if9.out_data}, 32'd0);
    check_eq("rst_busy", {31'd0, if9.busy}, 32'd0);
    rst = 1'b0;
    #1 check_eq("rel_in_ready_low", {31'd0, if9.in_ready}, 32'd0);
    @(posedge clk); @(negedge clk);
    check_eq("rel_in_ready_high", {31'd0, if9.in_ready}, 32'd1);

    // 1: ascending in, descending out, latency check
    load_win(v_up, 1'b0);
    wait_sort(1'b0);
    drain(e_dn, 1'b0, 1'b0);

    // 2: duplicates and extremes, with input gaps
    load_win(v_dup, 1'b1);
    wait_sort(1'b0);
    drain(e_dup, 1'b0, 1'b0);

    // 3: backpressure pattern 1,0,0,1
    load_win(v_dn, 1'b0);
    wait_sort(1'b0);
    drain(e_dn, 1'b1, 1'b0);

    // 4: reset during sort pass 4
    load_win(v_up, 1'b0);
    repeat (4) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    #1;
    check_eq("abort_in_ready", {31'd0, if9.in_ready}, 32'd0);
    check_eq("abort_out_valid", {31'd0, if9.out_valid}, 32'd0);
    check_eq("abort_out_data", {24'd0, if9.out_data}, 32'd0);
    check_eq("abort_out_last", {31'd0, if9.out_last}, 32'd0);
    check_eq("abort_busy", {31'd0, if9.busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check_eq("abort_rel_low", {31'd0, if9.in_ready}, 32'd0);
    @(posedge clk); @(negedge clk);
    check_eq("abort_rel_high", {31'd0, if9.in_ready}, 32'd1);
    load_win(v_mix, 1'b0);
    wait_sort(1'b0);
    drain(e_dn, 1'b0, 1'b0);

    // 5: in_valid held with 0xAA while sorting and draining
    load_win(v_aa, 1'b0);
    if9.in_valid = 1'b1;
    if9.in_data  = 8'hAA;
    wait_sort(1'b1);
    drain('{8'd250, 8'd171, 8'd169, 8'd100, 8'd17, 8'd4, 8'd4, 8'd2, 8'd0}, 1'b0, 1'b1);
    if9.in_valid = 1'b0;

    // 6: median vector (full stream in the default build)
    load_win(v_med, 1'b0);
    wait_sort(1'b0);
    drain(e_med, 1'b1, 1'b0);

    // NUM=2 instance: load 3,9 -> 9,3
    if2.out_ready = 1'b1;
    if2.in_valid  = 1'b1;
    if2.in_data   = 8'd3;
    check_eq("n2_in_ready0", {31'd0, if2.in_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    if2.in_data = 8'd9;
    check_eq("n2_in_ready1", {31'd0, if2.in_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    if2.in_valid = 1'b0;
    beat = 0;
    cyc  = 0;
    while (beat < N2 && cyc < 20) begin
      if (if2.out_valid) begin
        check_eq("n2_data", {24'd0, if2.out_data}, {24'd0, e2[beat]});
        check_eq("n2_last", {31'd0, if2.out_last}, {31'd0, beat == N2 - 1});
        beat++;
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    if (beat < N2) check_eq("n2_timeout", beat, N2);
    check_eq("n2_latency", cyc, 3 + N2 - 1);
    check_eq("n2_post_busy", {31'd0, if2.busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
